// File: rtl/dcache_axi_mem_responder_if.sv
// -----------------------------------------------------------------------------
// dcache_axi_mem_responder_if
// Bundle of the AXI4-Lite-style channels between the data-cache master port and
// the memory responder.
//   AW : AXI_AWVALID, AXI_AWREADY, AXI_AWADDR, AXI_AWPROT
//   W  : AXI_WVALID,  AXI_WREADY,  AXI_WDATA,  AXI_WSTRB
//   B  : AXI_BVALID,  AXI_BREADY,  AXI_BRESP
//   AR : AXI_ARVALID, AXI_ARREADY, AXI_ARADDR
//   R  : AXI_RVALID,  AXI_RREADY,  AXI_RDATA (one full line), AXI_RRESP
// Handshake rule for every channel: a transfer happens on the rising clock edge
// where VALID and READY are both 1; once VALID is raised, the payload stays
// stable until that edge.
// Modports: master (the cache side / bench), slave (the memory responder).
// -----------------------------------------------------------------------------
interface dcache_axi_mem_responder_if #(
   parameter int XLEN   = 32,
   parameter int D_WORD = 4
);
   logic                     AXI_AWVALID;
   logic                     AXI_AWREADY;
   logic [XLEN-1:0]          AXI_AWADDR;
   logic [2:0]               AXI_AWPROT;
   logic                     AXI_WVALID;
   logic                     AXI_WREADY;
   logic [XLEN-1:0]          AXI_WDATA;
   logic [3:0]               AXI_WSTRB;
   logic                     AXI_BVALID;
   logic [1:0]               AXI_BRESP;
   logic                     AXI_BREADY;
   logic                     AXI_ARVALID;
   logic                     AXI_ARREADY;
   logic [XLEN-1:0]          AXI_ARADDR;
   logic                     AXI_RVALID;
   logic [XLEN*D_WORD-1:0]   AXI_RDATA;
   logic [1:0]               AXI_RRESP;
   logic                     AXI_RREADY;

   modport master (
      output AXI_AWVALID, AXI_AWADDR, AXI_AWPROT, AXI_WVALID, AXI_WDATA, AXI_WSTRB,
             AXI_BREADY, AXI_ARVALID, AXI_ARADDR, AXI_RREADY,
      input  AXI_AWREADY, AXI_WREADY, AXI_BVALID, AXI_BRESP, AXI_ARREADY,
             AXI_RVALID, AXI_RDATA, AXI_RRESP
   );

   modport slave (
      input  AXI_AWVALID, AXI_AWADDR, AXI_AWPROT, AXI_WVALID, AXI_WDATA, AXI_WSTRB,
             AXI_BREADY, AXI_ARVALID, AXI_ARADDR, AXI_RREADY,
      output AXI_AWREADY, AXI_WREADY, AXI_BVALID, AXI_BRESP, AXI_ARREADY,
             AXI_RVALID, AXI_RDATA, AXI_RRESP
   );
endinterface

// File: rtl/dcache_axi_mem_responder.sv
// -----------------------------------------------------------------------------
// dcache_axi_mem_responder
// Backing data memory for the D-cache AXI master port. One transaction is in
// flight at a time: a single-word strobed write (AW + W, then B) or a full-line
// read (AR, READ_LAT wait cycles, then R carrying D_WORD words).
// Ports:
//   CLK          rising-edge clock
//   rst          synchronous active-high reset (memory contents are kept)
//   axi          dcache_axi_mem_responder_if.slave, all AXI channels
//   o_dbg_state  current FSM state (IDLE=0, W_DATA=1, B_RESP=2, R_WAIT=3, R_RESP=4)
// Optional build macro: DMEM_RANGE_CHECK_EN. When defined, an address whose
// word index is >= DEPTH answers SLVERR (write dropped, read data zero). When
// undefined, upper address bits are ignored and the index wraps modulo DEPTH.
// -----------------------------------------------------------------------------
module dcache_axi_mem_responder #(
   parameter int XLEN     = 32,
   parameter int D_WORD   = 4,
   parameter int DEPTH    = 1024,
   parameter int READ_LAT = 2
) (
   input  logic                          CLK,
   input  logic                          rst,
   dcache_axi_mem_responder_if.slave     axi,
   output logic [2:0]                    o_dbg_state
);
   localparam int IDX_W = $clog2(DEPTH);
`ifdef DMEM_RANGE_CHECK_EN
   localparam bit RANGE_CHK = 1'b1;
`else
   localparam bit RANGE_CHK = 1'b0;
`endif

   typedef enum logic [2:0] {S_IDLE, S_W_DATA, S_B_RESP, S_R_WAIT, S_R_RESP} state_t;

   state_t                 r_state, w_next;
   logic [XLEN-1:0]        r_mem [DEPTH];
   logic [IDX_W-1:0]       r_aw_idx, r_ar_idx;
   logic                   r_aw_err, r_ar_err;
   logic [3:0]             r_cnt;
   logic [1:0]             r_bresp, r_rresp;
   logic [XLEN*D_WORD-1:0] r_rdata;

   logic [IDX_W-1:0]       w_aw_idx, w_ar_idx, w_wr_idx, w_rd_idx, w_line_base;
   logic                   w_aw_err, w_ar_err, w_wr_err, w_rd_err;
   logic                   w_awready, w_wready, w_arready;
   logic                   w_wr_en, w_rd_load, w_ar_hs;
   logic [XLEN*D_WORD-1:0] w_line;
   logic                   w_unused;

   // Word index from the byte address; bits above the index only matter for
   // the range check.
   assign w_aw_idx = axi.AXI_AWADDR[IDX_W+1:2];
   assign w_ar_idx = axi.AXI_ARADDR[IDX_W+1:2];
   assign w_aw_err = RANGE_CHK && (|axi.AXI_AWADDR[XLEN-1:IDX_W+2]);
   assign w_ar_err = RANGE_CHK && (|axi.AXI_ARADDR[XLEN-1:IDX_W+2]);
   assign w_unused = ^{axi.AXI_AWPROT, axi.AXI_AWADDR[1:0], axi.AXI_ARADDR[1:0]};

   // Next state, readies and the write / read-capture strobes.
   always_comb begin
      w_next    = r_state;
      w_awready = 1'b0;
      w_wready  = 1'b0;
      w_arready = 1'b0;
      w_wr_en   = 1'b0;
      w_wr_idx  = r_aw_idx;
      w_wr_err  = r_aw_err;
      w_rd_load = 1'b0;
      w_rd_idx  = r_ar_idx;
      w_rd_err  = r_ar_err;
      w_ar_hs   = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_awready = 1'b1;
            w_arready = !axi.AXI_AWVALID;   // writes win a simultaneous request
            w_wready  = axi.AXI_AWVALID;
            if (axi.AXI_AWVALID) begin
               if (axi.AXI_WVALID) begin
                  w_wr_en  = 1'b1;
                  w_wr_idx = w_aw_idx;       // address not latched yet, use it live
                  w_wr_err = w_aw_err;
                  w_next   = S_B_RESP;
               end else begin
                  w_next = S_W_DATA;
               end
            end else if (axi.AXI_ARVALID) begin
               w_ar_hs = 1'b1;
               if (READ_LAT == 0) begin
                  w_next    = S_R_RESP;
                  w_rd_load = 1'b1;
                  w_rd_idx  = w_ar_idx;
                  w_rd_err  = w_ar_err;
               end else begin
                  w_next = S_R_WAIT;
               end
            end
         end
         S_W_DATA: begin
            w_wready = 1'b1;
            if (axi.AXI_WVALID) begin
               w_wr_en = 1'b1;
               w_next  = S_B_RESP;
            end
         end
         S_B_RESP: if (axi.AXI_BREADY) w_next = S_IDLE;
         S_R_WAIT: begin
            if (r_cnt <= 4'd1) begin
               w_next    = S_R_RESP;
               w_rd_load = 1'b1;
            end
         end
         S_R_RESP: if (axi.AXI_RREADY) w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
      // Nothing handshakes or touches memory while reset is held.
      if (rst) begin
         w_awready = 1'b0;
         w_wready  = 1'b0;
         w_arready = 1'b0;
         w_wr_en   = 1'b0;
         w_rd_load = 1'b0;
         w_ar_hs   = 1'b0;
      end
   end

   // Line gather: base index with the in-line word bits cleared.
   always_comb begin
      w_line_base = w_rd_idx & ~IDX_W'(D_WORD - 1);
      w_line      = '0;
      for (int i = 0; i < D_WORD; i++) begin
         w_line[XLEN*i +: XLEN] = r_mem[w_line_base + IDX_W'(i)];
      end
   end

   always_ff @(posedge CLK) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_bresp  <= '0;
         r_rresp  <= '0;
         r_rdata  <= '0;
         r_aw_idx <= '0;
         r_ar_idx <= '0;
         r_aw_err <= 1'b0;
         r_ar_err <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == S_IDLE && axi.AXI_AWVALID) begin
            r_aw_idx <= w_aw_idx;
            r_aw_err <= w_aw_err;
         end
         if (w_ar_hs) begin
            r_ar_idx <= w_ar_idx;
            r_ar_err <= w_ar_err;
            r_cnt    <= 4'(READ_LAT);
         end else if (r_state == S_R_WAIT) begin
            r_cnt <= r_cnt - 4'd1;
         end
         if (w_wr_en) r_bresp <= w_wr_err ? 2'b10 : 2'b00;
         if (w_rd_load) begin
            r_rresp <= w_rd_err ? 2'b10 : 2'b00;
            r_rdata <= w_rd_err ? '0 : w_line;
         end
      end
   end

   // Memory array has no reset.
   always_ff @(posedge CLK) begin
      if (w_wr_en && !w_wr_err) begin
         for (int b = 0; b < 4; b++) begin
            if (axi.AXI_WSTRB[b]) r_mem[w_wr_idx][8*b +: 8] <= axi.AXI_WDATA[8*b +: 8];
         end
      end
   end

   assign axi.AXI_AWREADY = w_awready;
   assign axi.AXI_WREADY  = w_wready;
   assign axi.AXI_ARREADY = w_arready;
   assign axi.AXI_BVALID  = !rst && (r_state == S_B_RESP);
   assign axi.AXI_RVALID  = !rst && (r_state == S_R_RESP);
   assign axi.AXI_BRESP   = r_bresp;
   assign axi.AXI_RRESP   = r_rresp;
   assign axi.AXI_RDATA   = r_rdata;
   assign o_dbg_state     = r_state;
endmodule

// File: tb/tb_dcache_axi_mem_responder.sv
module tb_dcache_axi_mem_responder;
   localparam int XLEN     = 32;
   localparam int D_WORD   = 4;
   localparam int DEPTH    = 1024;
   localparam int READ_LAT = 2;
   localparam int LINE_W   = XLEN * D_WORD;

   // ---------------- clock / reset ----------------
   logic CLK;
   logic rst;
   logic [2:0] dbg_state;

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   dcache_axi_mem_responder_if #(.XLEN(XLEN), .D_WORD(D_WORD)) ifc ();

   dcache_axi_mem_responder #(
      .XLEN(XLEN), .D_WORD(D_WORD), .DEPTH(DEPTH), .READ_LAT(READ_LAT)
   ) dut (
      .CLK        (CLK),
      .rst        (rst),
      .axi        (ifc),
      .o_dbg_state(dbg_state)
   );

   int n_pass;
   int n_total;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, %0d/%0d", n_pass, n_total);
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   logic [XLEN-1:0] model_mem [DEPTH];

   function automatic bit addr_err(input logic [31:0] a);
`ifdef DMEM_RANGE_CHECK_EN
      return (a / 4) >= DEPTH;
`else
      return 1'b0;
`endif
   endfunction

   function automatic int widx(input logic [31:0] a);
      return int'((a / 4) % DEPTH);
   endfunction

   function automatic logic [1:0] exp_resp(input logic [31:0] a);
      return addr_err(a) ? 2'b10 : 2'b00;
   endfunction

   task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] strb);
      int k;
      if (!addr_err(a)) begin
         k = widx(a);
         for (int b = 0; b < 4; b++)
            if (strb[b]) model_mem[k][8*b +: 8] = d[8*b +: 8];
      end
   endtask

   function automatic logic [LINE_W-1:0] model_line(input logic [31:0] a);
      logic [LINE_W-1:0] l;
      int base;
      l = '0;
      if (!addr_err(a)) begin
         base = widx(a) - (widx(a) % D_WORD);
         for (int i = 0; i < D_WORD; i++) l[XLEN*i +: XLEN] = model_mem[base + i];
      end
      return l;
   endfunction

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic fail_timeout(input string name);
      n_total++;
      $display("FAIL %s: timeout waiting for DUT, got none expected handshake", name);
   endtask

   // ---------------- driver tasks ----------------
   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int w_delay, input int b_hold);
      int n;
      logic [1:0] er;
      er = exp_resp(addr);
      @(negedge CLK);
      ifc.AXI_AWVALID = 1'b1;
      ifc.AXI_AWADDR  = addr;
      ifc.AXI_AWPROT  = 3'($urandom_range(0, 7));
      if (w_delay == 0) begin
         ifc.AXI_WVALID = 1'b1;
         ifc.AXI_WDATA  = data;
         ifc.AXI_WSTRB  = strb;
      end
      #1;
      n = 0;
      while (!ifc.AXI_AWREADY && n < 50) begin @(negedge CLK); #1; n++; end
      if (!ifc.AXI_AWREADY) begin
         fail_timeout("aw_ready");
         ifc.AXI_AWVALID = 1'b0;
         ifc.AXI_WVALID  = 1'b0;
         return;
      end
      @(posedge CLK);
      @(negedge CLK);
      ifc.AXI_AWVALID = 1'b0;
      if (w_delay > 0) begin
         #1;
         check("w_data_awready_low", ifc.AXI_AWREADY, 0);
         check("w_data_arready_low", ifc.AXI_ARREADY, 0);
         check("w_data_wready_high", ifc.AXI_WREADY, 1);
         repeat (w_delay - 1) @(negedge CLK);
         ifc.AXI_WVALID = 1'b1;
         ifc.AXI_WDATA  = data;
         ifc.AXI_WSTRB  = strb;
         #1;
         n = 0;
         while (!ifc.AXI_WREADY && n < 50) begin @(negedge CLK); #1; n++; end
         if (!ifc.AXI_WREADY) begin
            fail_timeout("w_ready");
            ifc.AXI_WVALID = 1'b0;
            return;
         end
         @(posedge CLK);
         @(negedge CLK);
      end
      ifc.AXI_WVALID = 1'b0;
      model_write(addr, data, strb);
      #1;
      n = 1;
      while (!ifc.AXI_BVALID && n < 50) begin @(negedge CLK); #1; n++; end
      if (!ifc.AXI_BVALID) begin fail_timeout("b_valid"); return; end
      check("b_latency", n, 1);
      check("b_resp", ifc.AXI_BRESP, er);
      for (int i = 0; i < b_hold; i++) begin
         @(negedge CLK); #1;
         check("b_hold_valid", ifc.AXI_BVALID, 1);
         check("b_hold_resp", ifc.AXI_BRESP, er);
      end
      ifc.AXI_BREADY = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      ifc.AXI_BREADY = 1'b0;
      #1;
      check("b_drop", ifc.AXI_BVALID, 0);
   endtask

   task automatic axi_read(input logic [31:0] addr, input int r_hold, output logic [LINE_W-1:0] got);
      int n;
      logic [LINE_W-1:0] el;
      logic [1:0] er;
      el  = model_line(addr);
      er  = exp_resp(addr);
      got = '0;
      @(negedge CLK);
      ifc.AXI_ARVALID = 1'b1;
      ifc.AXI_ARADDR  = addr;
      #1;
      n = 0;
      while (!ifc.AXI_ARREADY && n < 50) begin @(negedge CLK); #1; n++; end
      if (!ifc.AXI_ARREADY) begin
         fail_timeout("ar_ready");
         ifc.AXI_ARVALID = 1'b0;
         return;
      end
      @(posedge CLK);
      @(negedge CLK);
      ifc.AXI_ARVALID = 1'b0;
      #1;
      n = 1;
      while (!ifc.AXI_RVALID && n < 50) begin @(negedge CLK); #1; n++; end
      if (!ifc.AXI_RVALID) begin fail_timeout("r_valid"); return; end
      got = ifc.AXI_RDATA;
      check("r_latency", n, READ_LAT + 1);
      check("r_data", ifc.AXI_RDATA, el);
      check("r_resp", ifc.AXI_RRESP, er);
      for (int i = 0; i < r_hold; i++) begin
         @(negedge CLK); #1;
         check("r_hold_valid", ifc.AXI_RVALID, 1);
         check("r_hold_data", ifc.AXI_RDATA, el);
         check("r_hold_resp", ifc.AXI_RRESP, er);
      end
      ifc.AXI_RREADY = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      ifc.AXI_RREADY = 1'b0;
      #1;
      check("r_drop", ifc.AXI_RVALID, 0);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [31:0] addr;
      logic [31:0] pre;
      logic [31:0] data;
      logic [3:0]  strb;
      int          w_delay;
      int          b_hold;
      logic [31:0] exp_word;
   } vec_t;

   vec_t vecs [5];

   // ---------------- main sequence ----------------
   initial begin
      logic [LINE_W-1:0] got;
      logic [31:0] a, d;
      int n;
      n_pass = 0;
      n_total = 0;
      rst = 1'b1;
      ifc.AXI_AWVALID = 0; ifc.AXI_AWADDR = 0; ifc.AXI_AWPROT = 0;
      ifc.AXI_WVALID = 0;  ifc.AXI_WDATA = 0;  ifc.AXI_WSTRB = 0;
      ifc.AXI_BREADY = 0;  ifc.AXI_ARVALID = 0; ifc.AXI_ARADDR = 0;
      ifc.AXI_RREADY = 0;

      vecs[0] = '{32'h20, 32'hAAAAAAAA, 32'h11223344, 4'b0101, 3, 4, 32'hAA22AA44};
      vecs[1] = '{32'h24, 32'h00000000, 32'hCAFEBABE, 4'b1111, 0, 0, 32'hCAFEBABE};
      vecs[2] = '{32'h28, 32'h12345678, 32'hFFFFFFFF, 4'b0000, 1, 1, 32'h12345678};
      vecs[3] = '{32'h2C, 32'h00000000, 32'hDEADBEEF, 4'b1010, 2, 2, 32'hDE00BE00};
      vecs[4] = '{32'h32, 32'hFFFFFFFF, 32'h00000000, 4'b0001, 0, 3, 32'hFFFFFF00};

      // reset state
      repeat (2) @(negedge CLK);
      #1;
      check("rst_awready", ifc.AXI_AWREADY, 0);
      check("rst_arready", ifc.AXI_ARREADY, 0);
      check("rst_wready",  ifc.AXI_WREADY, 0);
      check("rst_bvalid",  ifc.AXI_BVALID, 0);
      check("rst_rvalid",  ifc.AXI_RVALID, 0);
      @(negedge CLK);
      rst = 1'b0;
      #1;
      check("post_rst_awready", ifc.AXI_AWREADY, 1);
      check("post_rst_arready", ifc.AXI_ARREADY, 1);
      check("post_rst_bresp",   ifc.AXI_BRESP, 0);
      check("post_rst_rresp",   ifc.AXI_RRESP, 0);
      check("post_rst_rdata",   ifc.AXI_RDATA, 0);
      check("post_rst_state",   dbg_state, 0);

      // give every word the bench may read a known value
      for (int i = 0; i < 64; i++) axi_write(32'(i * 4), $urandom, 4'hF, 0, 0);
      axi_write(32'hFFC, $urandom, 4'hF, 0, 0);

      // same-cycle AW/W, then line readback with word 4 in lane 0
      axi_write(32'h10, 32'hCAFEBABE, 4'hF, 0, 0);
      axi_read(32'h10, 0, got);
      check("w10_lane0", got[31:0], 32'hCAFEBABE);

      // read latency and RDATA hold; 0x1C lives in the line based at 0x10
      axi_read(32'h1C, 3, got);
      check("r1c_lane0", got[31:0], 32'hCAFEBABE);

      // table: pre-load, strobed write, readback of the written lane
      for (int v = 0; v < 5; v++) begin
         axi_write(vecs[v].addr, vecs[v].pre, 4'hF, 0, 0);
         axi_write(vecs[v].addr, vecs[v].data, vecs[v].strb, vecs[v].w_delay, vecs[v].b_hold);
         axi_read(vecs[v].addr, v % 2, got);
         check($sformatf("vec%0d_word", v), got[XLEN*((vecs[v].addr / 4) % D_WORD) +: XLEN],
               vecs[v].exp_word);
      end

      // AW and AR together: write first, read afterwards sees the new data
      @(negedge CLK);
      ifc.AXI_AWVALID = 1'b1; ifc.AXI_AWADDR = 32'h40;
      ifc.AXI_WVALID  = 1'b1; ifc.AXI_WDATA  = 32'h5A5A0F0F; ifc.AXI_WSTRB = 4'hF;
      ifc.AXI_ARVALID = 1'b1; ifc.AXI_ARADDR = 32'h44;
      #1;
      check("both_awready", ifc.AXI_AWREADY, 1);
      check("both_arready_low", ifc.AXI_ARREADY, 0);
      @(posedge CLK);
      @(negedge CLK);
      ifc.AXI_AWVALID = 1'b0;
      ifc.AXI_WVALID  = 1'b0;
      model_write(32'h40, 32'h5A5A0F0F, 4'hF);
      #1;
      check("both_bvalid", ifc.AXI_BVALID, 1);
      check("both_arready_in_b", ifc.AXI_ARREADY, 0);
      ifc.AXI_BREADY = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      ifc.AXI_BREADY = 1'b0;
      #1;
      check("both_arready_idle", ifc.AXI_ARREADY, 1);
      @(posedge CLK);
      @(negedge CLK);
      ifc.AXI_ARVALID = 1'b0;
      #1;
      n = 1;
      while (!ifc.AXI_RVALID && n < 50) begin @(negedge CLK); #1; n++; end
      check("both_r_latency", n, READ_LAT + 1);
      check("both_r_data", ifc.AXI_RDATA, model_line(32'h44));
      check("both_r_lane0", ifc.AXI_RDATA[31:0], 32'h5A5A0F0F);
      ifc.AXI_RREADY = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      ifc.AXI_RREADY = 1'b0;

      // reset while waiting for read data
      ifc.AXI_ARVALID = 1'b1; ifc.AXI_ARADDR = 32'h80;
      #1;
      check("rwait_arready", ifc.AXI_ARREADY, 1);
      @(posedge CLK);
      @(negedge CLK);
      ifc.AXI_ARVALID = 1'b0;
      #1;
      check("rwait_state", dbg_state, 3);
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         #1;
         check("rwait_rst_awready", ifc.AXI_AWREADY, 0);
         check("rwait_rst_arready", ifc.AXI_ARREADY, 0);
         check("rwait_rst_wready",  ifc.AXI_WREADY, 0);
         check("rwait_rst_rvalid",  ifc.AXI_RVALID, 0);
         @(negedge CLK);
      end
      rst = 1'b0;
      #1;
      check("rwait_release_awready", ifc.AXI_AWREADY, 1);
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK); #1;
         check("rwait_no_rvalid", ifc.AXI_RVALID, 0);
      end

      // out-of-range address: SLVERR with the range check, wrap to word 0 without
      axi_write(32'h1000, 32'hBADBADBA, 4'hF, 0, 0);
      axi_read(32'h0, 0, got);
      axi_read(32'h1000, 0, got);

      // randomized traffic against the model
      for (int t = 0; t < 60; t++) begin
         a = 32'($urandom_range(0, 63) * 4 + $urandom_range(0, 3));
         if ($urandom_range(0, 7) == 0) a = a | 32'h1000;
         if ($urandom_range(0, 1) == 1) begin
            d = $urandom;
            axi_write(a, d, 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 2));
         end else begin
            axi_read(a, $urandom_range(0, 2), got);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/dcache_axi_mem_responder.md
Name: dcache_axi_mem_responder

Overview:
- AXI4-Lite-style memory responder (subordinate) for the core's data-cache AXI master port.
- Read channel returns a full cache line of D_WORD words per AR handshake.
- Write channel accepts one 32-bit word with byte strobes per AW/W pair.
- Used as the backing data memory in core-level integration and as a bench model, replacing hand-driven D-cache stimulus.

Parameters:
- XLEN, 32, data word width in bits
- D_WORD, 4, words per cache line returned on RDATA (power of 2)
- DEPTH, 1024, memory depth in XLEN words (power of 2)
- READ_LAT, 2, extra wait cycles between AR handshake and RVALID (0..15)

Ports:
- CLK  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- AXI_AWVALID  in  1  write address valid
- AXI_AWREADY  out  1  write address ready
- AXI_AWADDR  in  XLEN  byte write address
- AXI_AWPROT  in  3  ignored
- AXI_WVALID  in  1  write data valid
- AXI_WREADY  out  1  write data ready
- AXI_WDATA  in  XLEN  write word
- AXI_WSTRB  in  4  byte enables, bit i = WDATA[8i+7:8i]
- AXI_BVALID  out  1  write response valid
- AXI_BRESP  out  2  00 OKAY, 10 SLVERR
- AXI_BREADY  in  1  write response ready
- AXI_ARVALID  in  1  read address valid
- AXI_ARREADY  out  1  read address ready
- AXI_ARADDR  in  XLEN  byte read address
- AXI_RVALID  out  1  read data valid
- AXI_RDATA  out  XLEN*D_WORD  read line
- AXI_RRESP  out  2  00 OKAY, 10 SLVERR
- AXI_RREADY  in  1  read data ready

Behaviour:
- Reset (rst=1 at a CLK edge):
  - FSM goes to IDLE; wait counter cleared.
  - BVALID, RVALID, AWREADY, WREADY and ARREADY are 0 while rst=1.
  - BRESP, RRESP and RDATA are 0.
  - Memory contents are not reset.
- Reset mid-transaction aborts it. Any write that has not completed its W handshake is discarded; no B or R response is issued.
- Word index = ADDR[log2(DEPTH)+1:2]; ADDR[1:0] ignored.
- Line base = word index with its low log2(D_WORD) bits cleared.
- RDATA[XLEN*i +: XLEN] = mem[line_base+i] for i = 0..D_WORD-1.
- FSM states: IDLE, W_DATA, B_RESP, R_WAIT, R_RESP.
- IDLE:
  - AWREADY = 1.
  - ARREADY = !AWVALID, so writes take priority over a simultaneous read.
  - WREADY = AWVALID.
- AWVALID in IDLE: latch AWADDR.
  - If WVALID is also 1, write strobed bytes at that edge and go to B_RESP.
  - Otherwise go to W_DATA.
- W_DATA: WREADY = 1. On WVALID, write strobed bytes and go to B_RESP. Only WREADY is high; AWREADY = ARREADY = 0.
- B_RESP:
  - BVALID = 1; BRESP held stable until BREADY.
  - On BVALID&BREADY, go to IDLE; BVALID drops next cycle.
- WSTRB = 0000: memory unchanged, BRESP = OKAY.
- ARVALID&ARREADY in IDLE: latch ARADDR and load counter with READ_LAT.
  - READ_LAT = 0: go straight to R_RESP.
  - Otherwise go to R_WAIT and decrement each cycle; at 1, go to R_RESP.
  - First RVALID cycle = AR handshake cycle + READ_LAT + 1.
- R_RESP:
  - RDATA is captured from memory on entry.
  - RVALID, RDATA and RRESP stay stable until RREADY.
  - On RVALID&RREADY, go to IDLE.
- Exactly one outstanding transaction; no new AR or AW is accepted outside IDLE.
- Back-to-back: a new AW/AR can be accepted the cycle after returning to IDLE, so minimum write turnaround is 2 cycles.

Optional Feature:
- Macro: DMEM_RANGE_CHECK_EN.
- Defined:
  - A word index ≥ DEPTH, i.e. any ADDR bit above log2(DEPTH)+1 set, gives SLVERR.
  - Write: BRESP = 10 and memory is not modified.
  - Read: RRESP = 10 and RDATA = 0.
- Undefined: upper address bits are ignored, the address wraps modulo DEPTH words, and responses are always OKAY.

Test Plan:
- Write, AW and W same cycle: AWADDR = 0x10, WDATA = 0xCAFEBABE, WSTRB = 1111, BREADY = 1 → BVALID the next cycle with BRESP = 00. A following read of 0x10 returns RDATA = {mem[7], mem[6], mem[5], 0xCAFEBABE} (word 4 in lane 0).
- Staggered W: AW at 0x20 in cycle t, W with WDATA = 0x11223344 / WSTRB = 0101 three cycles later over old 0xAAAAAAAA → word becomes 0xAA22AA44. BVALID is held 4 cycles with BREADY = 0 and stays stable.
- Read latency with READ_LAT = 2, ARADDR = 0x1C, RREADY held 0 for 3 cycles → RVALID rises exactly 3 cycles after the AR handshake. RDATA holds the line for base 0x10 unchanged until RREADY.
- AWVALID and ARVALID asserted together in IDLE → AW accepted, ARREADY = 0. The read is accepted only after BVALID&BREADY, and returns the newly written data.
- rst asserted while in R_WAIT → RVALID never rises, all readies are 0 during reset, and AWREADY = 1 on the first cycle after release.
- With DMEM_RANGE_CHECK_EN and DEPTH = 1024, write to 0x1000 → BRESP = 10, and word 0 is unchanged on readback. Without the macro, the same write lands in word 0 with BRESP = 00.
